// File: rtl/multdiv_unit_pkg.sv
// Shared state encodings and constants for the iterative multiply/divide unit.
package multdiv_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int ITER = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division iteration on an unsigned {remainder, quotient} pair.
module div_step
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] rq_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Remainder stays below the divisor magnitude, so the difference fits back in WIDTH bits.
  always_comb begin
    shifted = {rq_in[2*WIDTH-1:WIDTH], rq_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    rq_out  = {shifted[WIDTH-1:0], rq_in[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rq_out = {trial[WIDTH-1:0], rq_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (radix-2 Booth) / divider (restoring) with a fixed
// ITER-cycle latency; one operation in flight, restartable by a new start pulse.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = multdiv_unit_pkg::ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(ITER);
  localparam int BW    = 2 * WIDTH + 2;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  state_e                  state, state_n;
  logic [CNT_W-1:0]        counter;
  logic [WIDTH-1:0]        op_a, op_b, b_mag;
  logic [BW-1:0]           booth, booth_n;
  logic [2*WIDTH-1:0]      rq, rq_n;
  logic signed [WIDTH:0]   acc, a_ext, acc_sum;
  logic [WIDTH-1:0]        mul_res, div_res, quo;
  logic                    mul_exc, div_exc;
  logic                    start, last;

  assign start          = ctrl_MULT | ctrl_DIV;
  assign last           = (counter == CNT_W'(ITER - 1));
  assign data_resultRDY = (state == S_DONE);
  assign busy           = (state != S_IDLE);

  // Booth step; the accumulator carries one guard bit so subtracting INT_MIN cannot wrap.
  always_comb begin
    acc   = booth[BW-1 -: WIDTH+1];
    a_ext = {op_a[WIDTH-1], op_a};
    case (booth[1:0])
      2'b01:   acc_sum = acc + a_ext;
      2'b10:   acc_sum = acc - a_ext;
      default: acc_sum = acc;
    endcase
    booth_n = {acc_sum[WIDTH], acc_sum, booth[WIDTH:1]};
    mul_res = booth_n[WIDTH:1];
    mul_exc = !((&booth_n[2*WIDTH:WIDTH]) || (~|booth_n[2*WIDTH:WIDTH]));
  end

  assign b_mag = mag(op_b);

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rq_in  (rq),
    .divisor(b_mag),
    .rq_out (rq_n)
  );

  always_comb begin
    quo     = rq_n[WIDTH-1:0];
    div_exc = 1'b0;
    div_res = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) ? (~quo + WIDTH'(1)) : quo;
    if (op_b == '0) begin
      div_res = '0;
      div_exc = 1'b1;
    end else if ((op_a == WIDTH'(INT_MIN)) && (op_b == '1)) begin
      div_res = WIDTH'(INT_MIN);
      div_exc = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    if (ctrl_MULT) begin
      state_n = S_MULT;
    end else if (ctrl_DIV) begin
      state_n = S_DIV;
    end else begin
      case (state)
        S_MULT, S_DIV: if (last) state_n = S_DONE;
        S_DONE:        state_n = S_IDLE;
        default:       state_n = state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= S_IDLE;
      counter        <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        counter <= '0;
      end else if ((state == S_MULT) || (state == S_DIV)) begin
        counter <= last ? '0 : counter + CNT_W'(1);
        if (last) begin
          data_result    <= (state == S_MULT) ? mul_res : div_res;
          data_exception <= (state == S_MULT) ? mul_exc : div_exc;
        end
      end
    end
  end

  // Operand and iteration registers; gated by the FSM, so they carry no reset.
  always_ff @(posedge clock) begin
    if (start) begin
      op_a  <= data_operandA;
      op_b  <= data_operandB;
      booth <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
      rq    <= {{WIDTH{1'b0}}, mag(data_operandA)};
    end else begin
      booth <= booth_n;
      rq    <= rq_n;
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, results, exceptions, abort and reset.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int errors = 0;

  multdiv_unit dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives a start pulse through edge E0, then scrambles the operand bus.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    step();
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_F00D;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp_res, input logic exp_exc);
    int   n;
    logic busy_ok;
    n       = 0;
    busy_ok = busy;
    while (!data_resultRDY && n < 40) begin
      step();
      n++;
      busy_ok = busy_ok & busy;
    end
    check({tag, "_latency"}, 32'(n), 32'd32);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_result"}, data_result, exp_res);
    check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    step();
    check({tag, "_rdy_after"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic seen;
    reset         = 1'b0;
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    step();
    step();
    ctrl_MULT = 1'b0;
    check("rst_result", data_result, 32'd0);
    check("rst_exc", {31'd0, data_exception}, 32'd0);
    check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    step();

    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    wait_result("mul_7x-6", 32'hFFFF_FFD6, 1'b0);
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_result("mul_ovf", 32'h0000_0000, 1'b1);
    start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_result("mul_m1xmin", 32'h8000_0000, 1'b1);
    start_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    wait_result("mul_m3xm5", 32'd15, 1'b0);

    start_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_result("div_100_m7", 32'hFFFF_FFF2, 1'b0);
    start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_result("div_m100_m7", 32'd14, 1'b0);
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    wait_result("div_by0", 32'd0, 1'b1);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_min_m1", 32'h8000_0000, 1'b1);

    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    seen = 1'b0;
    repeat (9) begin
      step();
      seen = seen | data_resultRDY;
    end
    check("abort_no_rdy", {31'd0, seen}, 32'd0);
    start_op(1'b0, 1'b1, 32'd9, 32'd2);
    wait_result("abort_div", 32'd4, 1'b0);

    start_op(1'b1, 1'b1, 32'd6, 32'd2);
    wait_result("both_mult", 32'd12, 1'b0);

    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (14) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_result", data_result, 32'd0);
    check("midrst_exc", {31'd0, data_exception}, 32'd0);
    check("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      step();
      seen = seen | data_resultRDY | busy;
    end
    check("midrst_quiet", {31'd0, seen}, 32'd0);
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    wait_result("mul_2x3", 32'd6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
